m_pc_pipeline: RTL and testbench

Parametrised program-counter unit with PC history pipeline for the CLD pipelined processor.
- Holds the fetch PC and advances it by a fixed increment each cycle.
- Accepts a stall and a branch/jump redirect.
- Carries each fetched PC, with a valid bit, down a STAGES-deep register chain (IF, ID, EX, ...) so every stage knows its instruction's PC.
- Successor to the fixed two-register PC/IF-PC pair: adds width, depth, stall, redirect and flush.

---
 rtl/m_pc_pipeline.sv | 111 +++++++++++
 tb/tb_m_pc_pipeline.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_pc_pipeline.sv
// Fetch program counter plus a STAGES-deep PC/valid history chain, with stall, redirect and flush.
// Define PC_MISALIGN_TRAP_EN to send misaligned redirects to TRAP_VEC and pulse w_misalign.
`timescale 1ns/1ps

module m_pc_pipeline #(
  parameter int              XLEN         = 32,
  parameter int              STAGES       = 3,
  parameter int              INC          = 4,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              FLUSH_STAGES = 2,
  parameter logic [XLEN-1:0] TRAP_VEC     = XLEN'('h100)
) (
  input  logic                   w_clk,
  input  logic                   w_rst,
  input  logic                   w_stall,
  input  logic                   w_redirect,
  input  logic [XLEN-1:0]        w_redirect_pc,
  output logic [XLEN-1:0]        w_pc,
  output logic [STAGES*XLEN-1:0] w_stage_pc,
`ifdef PC_MISALIGN_TRAP_EN
  output logic                   w_misalign,
`endif
  output logic [STAGES-1:0]      w_stage_valid
);

  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_stage_pc [STAGES];
  logic [STAGES-1:0] r_valid;

  logic [XLEN-1:0]   pc_nxt;
  logic [STAGES-1:0] valid_nxt;
  logic              advance;

  // A redirect always moves the pipeline, even when a stall is requested.
  assign advance = w_redirect || !w_stall;

`ifdef PC_MISALIGN_TRAP_EN
  logic misalign_nxt;
  logic r_misalign;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pc_nxt = r_pc + XLEN'(INC);
`ifdef PC_MISALIGN_TRAP_EN
    misalign_nxt = 1'b0;
`endif
    if (w_redirect) begin
      pc_nxt = w_redirect_pc;
`ifdef PC_MISALIGN_TRAP_EN
      if (w_redirect_pc[1:0] != 2'b00) begin
        pc_nxt       = TRAP_VEC;
        misalign_nxt = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    valid_nxt    = '0;
    valid_nxt[0] = 1'b1;
    for (int i = 1; i < STAGES; i++) begin
      valid_nxt[i] = r_valid[i-1];
    end
    // Squash the youngest stages: they hold wrong-path fetches once a redirect is taken.
    if (w_redirect) begin
      for (int i = 0; i < FLUSH_STAGES; i++) begin
        valid_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge w_clk) begin
    // NOTE: state registers use non-blocking assignment so every stage samples its predecessor's old value.
    if (w_rst) begin
      r_pc    <= RESET_PC;
      r_valid <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_stage_pc[i] <= '0;
      end
    end else if (advance) begin
      r_pc          <= pc_nxt;
      r_valid       <= valid_nxt;
      r_stage_pc[0] <= r_pc;
      for (int i = 1; i < STAGES; i++) begin
        r_stage_pc[i] <= r_stage_pc[i-1];
      end
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  // Cleared on every other edge, stalled or not, so the pulse lasts exactly one cycle.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= misalign_nxt;
    end
  end

  assign w_misalign = r_misalign;
`endif

  assign w_pc          = r_pc;
  assign w_stage_valid = r_valid;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage_out
    assign w_stage_pc[g*XLEN +: XLEN] = r_stage_pc[g];
  end

endmodule

// File: tb/tb_m_pc_pipeline.sv
// Self-checking bench for m_pc_pipeline: directed scenarios plus randomized traffic
// compared against a queue-based history model.
`timescale 1ns/1ps

module tb_m_pc_pipeline;

  localparam int          XLEN   = 32;
  localparam int          STAGES = 3;
  localparam int          FLUSH  = 2;
  localparam int          INC    = 4;
  localparam logic [31:0] RST_PC = 32'h0;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] TRAP   = 32'h100;

  logic                   w_clk = 1'b0;
  logic                   w_rst = 1'b0;
  logic                   w_stall = 1'b0;
  logic                   w_redirect = 1'b0;
  logic [XLEN-1:0]        w_redirect_pc = '0;
  logic [XLEN-1:0]        w_pc;
  logic [STAGES*XLEN-1:0] w_stage_pc;
  logic [STAGES-1:0]      w_stage_valid;

  logic                   w2_rst = 1'b0;
  logic                   w2_stall = 1'b0;
  logic                   w2_redirect = 1'b0;
  logic [XLEN-1:0]        w2_redirect_pc = '0;
  logic [XLEN-1:0]        w2_pc;
  logic [STAGES*XLEN-1:0] w2_stage_pc;
  logic [STAGES-1:0]      w2_stage_valid;

`ifdef PC_MISALIGN_TRAP_EN
  logic w_misalign;
  logic w2_misalign;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 w_clk = ~w_clk;

  m_pc_pipeline #(.XLEN(XLEN), .STAGES(STAGES), .INC(INC), .RESET_PC(RST_PC),
                  .FLUSH_STAGES(FLUSH), .TRAP_VEC(TRAP)) u_main (
    .w_clk         (w_clk),
    .w_rst         (w_rst),
    .w_stall       (w_stall),
    .w_redirect    (w_redirect),
    .w_redirect_pc (w_redirect_pc),
    .w_pc          (w_pc),
    .w_stage_pc    (w_stage_pc),
`ifdef PC_MISALIGN_TRAP_EN
    .w_misalign    (w_misalign),
`endif
    .w_stage_valid (w_stage_valid)
  );

  m_pc_pipeline #(.XLEN(XLEN), .STAGES(STAGES), .INC(INC), .RESET_PC(WRAP_PC),
                  .FLUSH_STAGES(FLUSH), .TRAP_VEC(TRAP)) u_wrap (
    .w_clk         (w_clk),
    .w_rst         (w2_rst),
    .w_stall       (w2_stall),
    .w_redirect    (w2_redirect),
    .w_redirect_pc (w2_redirect_pc),
    .w_pc          (w2_pc),
    .w_stage_pc    (w2_stage_pc),
`ifdef PC_MISALIGN_TRAP_EN
    .w_misalign    (w2_misalign),
`endif
    .w_stage_valid (w2_stage_valid)
  );

  // Reference model: the fetch PC plus a history queue, youngest entry at index 0.
  typedef struct {
    logic [31:0] pc;
    bit          v;
  } ent_t;

  logic [31:0] m_pc;
  ent_t        hist[$];
  bit          m_mis;

  function automatic logic [31:0] spc(input int i);
    return w_stage_pc[i*XLEN +: XLEN];
  endfunction

  function automatic logic [STAGES-1:0] m_valids();
    logic [STAGES-1:0] v;
    for (int i = 0; i < STAGES; i++) v[i] = hist[i].v;
    return v;
  endfunction

  // Drives one clock of stimulus on the main DUT and advances the model; returns at the next negedge.
  task automatic step(input logic rst, input logic stall, input logic redir, input logic [31:0] tgt);
    w_rst = rst; w_stall = stall; w_redirect = redir; w_redirect_pc = tgt;
    @(posedge w_clk);
    if (rst) begin
      m_pc = RST_PC;
      m_mis = 1'b0;
      hist.delete();
      for (int i = 0; i < STAGES; i++) hist.push_back('{pc: 32'h0, v: 1'b0});
    end else if (redir || !stall) begin
      hist.push_front('{pc: m_pc, v: 1'b1});
      void'(hist.pop_back());
      m_mis = 1'b0;
      if (redir) begin
        for (int i = 0; i < FLUSH; i++) hist[i].v = 1'b0;
        m_pc = tgt;
`ifdef PC_MISALIGN_TRAP_EN
        if (tgt[1:0] != 2'b00) begin
          m_pc  = TRAP;
          m_mis = 1'b1;
        end
`endif
      end else begin
        m_pc = m_pc + 32'(INC);
      end
    end else begin
      m_mis = 1'b0;
    end
    @(negedge w_clk);
    w_rst = 1'b0; w_stall = 1'b0; w_redirect = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (w_pc !== 32'h0) $display("FAIL reset_pc: got %h want %h", w_pc, 32'h0);
    else n_pass++;
    n_checks++;
    if (w_stage_valid !== 3'b000) $display("FAIL reset_valid: got %b want %b", w_stage_valid, 3'b000);
    else n_pass++;
    n_checks++;
    if (w_stage_pc !== '0) $display("FAIL reset_stage_pc: got %h want 0", w_stage_pc);
    else n_pass++;
  endtask

  task automatic test_free_run();
    logic [2:0] exp_v;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      exp_v = (k >= 3) ? 3'b111 : (k == 2) ? 3'b011 : 3'b001;
      n_checks++;
      if (w_pc !== 32'(4*k)) $display("FAIL run_pc[%0d]: got %h want %h", k, w_pc, 32'(4*k));
      else n_pass++;
      n_checks++;
      if (spc(0) !== 32'(4*(k-1))) $display("FAIL run_stage0[%0d]: got %h want %h", k, spc(0), 32'(4*(k-1)));
      else n_pass++;
      n_checks++;
      if (w_stage_valid !== exp_v) $display("FAIL run_valid[%0d]: got %b want %b", k, w_stage_valid, exp_v);
      else n_pass++;
      if (k >= 3) begin
        n_checks++;
        if (spc(2) !== 32'(4*(k-3))) $display("FAIL run_stage2[%0d]: got %h want %h", k, spc(2), 32'(4*(k-3)));
        else n_pass++;
      end
    end
  endtask

  task automatic test_stall();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      n_checks++;
      if (w_pc !== 32'd8 || spc(0) !== 32'd4 || spc(1) !== 32'd0 || w_stage_valid !== 3'b011)
        $display("FAIL stall_hold[%0d]: got pc=%h s0=%h s1=%h v=%b want pc=8 s0=4 s1=0 v=011",
                 k, w_pc, spc(0), spc(1), w_stage_valid);
      else n_pass++;
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (w_pc !== 32'd12 || spc(0) !== 32'd8 || w_stage_valid !== 3'b111)
      $display("FAIL stall_resume1: got pc=%h s0=%h v=%b want pc=c s0=8 v=111", w_pc, spc(0), w_stage_valid);
    else n_pass++;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (w_pc !== 32'd16) $display("FAIL stall_resume2: got %h want %h", w_pc, 32'd16);
    else n_pass++;
  endtask

  task automatic test_redirect();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h40);
    n_checks++;
    if (w_pc !== 32'h40) $display("FAIL redir_pc: got %h want %h", w_pc, 32'h40);
    else n_pass++;
    n_checks++;
    if (w_stage_valid !== 3'b100) $display("FAIL redir_valid: got %b want %b", w_stage_valid, 3'b100);
    else n_pass++;
    n_checks++;
    if (spc(2) !== 32'd8) $display("FAIL redir_stage2: got %h want %h", spc(2), 32'd8);
    else n_pass++;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (w_pc !== 32'h44 || spc(0) !== 32'h40 || w_stage_valid !== 3'b001)
      $display("FAIL redir_next: got pc=%h s0=%h v=%b want pc=44 s0=40 v=001", w_pc, spc(0), w_stage_valid);
    else n_pass++;
  endtask

  task automatic test_redirect_stall();
    step(1'b0, 1'b1, 1'b1, 32'h80);
    n_checks++;
    if (w_pc !== 32'h80 || w_stage_valid !== 3'b000)
      $display("FAIL redir_stall: got pc=%h v=%b want pc=80 v=000", w_pc, w_stage_valid);
    else n_pass++;
    step(1'b0, 1'b1, 1'b1, 32'h200);
    n_checks++;
    if (w_pc !== 32'h200 || w_stage_valid !== 3'b000)
      $display("FAIL redir_b2b: got pc=%h v=%b want pc=200 v=000", w_pc, w_stage_valid);
    else n_pass++;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (w_pc !== 32'h204 || spc(0) !== 32'h200 || w_stage_valid !== 3'b001)
      $display("FAIL redir_stall_next: got pc=%h s0=%h v=%b want pc=204 s0=200 v=001", w_pc, spc(0), w_stage_valid);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc[4];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0; exp_pc[3] = 32'h4;
    w2_rst = 1'b1;
    @(posedge w_clk); @(negedge w_clk);
    w2_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (w2_pc !== exp_pc[k]) $display("FAIL wrap_pc[%0d]: got %h want %h", k, w2_pc, exp_pc[k]);
      else n_pass++;
      @(posedge w_clk); @(negedge w_clk);
    end
    w2_rst = 1'b1;
    @(posedge w_clk); @(negedge w_clk);
    w2_rst = 1'b0;
    n_checks++;
    if (w2_pc !== WRAP_PC || w2_stage_valid !== 3'b000)
      $display("FAIL wrap_midreset: got pc=%h v=%b want pc=%h v=000", w2_pc, w2_stage_valid, WRAP_PC);
    else n_pass++;
  endtask

`ifdef PC_MISALIGN_TRAP_EN
  task automatic test_misalign();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h42);
    n_checks++;
    if (w_pc !== TRAP || w_misalign !== 1'b1)
      $display("FAIL misalign_trap: got pc=%h mis=%b want pc=%h mis=1", w_pc, w_misalign, TRAP);
    else n_pass++;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_checks++;
    if (w_misalign !== 1'b0) $display("FAIL misalign_pulse: got %b want 0", w_misalign);
    else n_pass++;
    step(1'b0, 1'b0, 1'b1, 32'h40);
    n_checks++;
    if (w_pc !== 32'h40 || w_misalign !== 1'b0)
      $display("FAIL misalign_aligned: got pc=%h mis=%b want pc=40 mis=0", w_pc, w_misalign);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    logic        rst, stall, redir;
    logic [31:0] tgt;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 59) == 0);
      stall = ($urandom_range(0, 3) == 0);
      redir = ($urandom_range(0, 5) == 0);
      tgt   = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      step(rst, stall, redir, tgt);
      n_checks++;
      if (w_pc !== m_pc) $display("FAIL rand_pc[%0d]: got %h want %h", n, w_pc, m_pc);
      else n_pass++;
      n_checks++;
      if (w_stage_valid !== m_valids())
        $display("FAIL rand_valid[%0d]: got %b want %b", n, w_stage_valid, m_valids());
      else n_pass++;
      for (int i = 0; i < STAGES; i++) begin
        if (hist[i].v) begin
          n_checks++;
          if (spc(i) !== hist[i].pc)
            $display("FAIL rand_stage%0d[%0d]: got %h want %h", i, n, spc(i), hist[i].pc);
          else n_pass++;
        end
      end
`ifdef PC_MISALIGN_TRAP_EN
      n_checks++;
      if (w_misalign !== m_mis) $display("FAIL rand_misalign[%0d]: got %b want %b", n, w_misalign, m_mis);
      else n_pass++;
`endif
    end
  endtask

  initial begin
    @(negedge w_clk);
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
`ifdef PC_MISALIGN_TRAP_EN
    test_misalign();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
